// File: rtl/button_ctrl.sv
// Push-button front end: synchronises raw buttons, debounces one accepted key at a time
// on a shared counter, and emits single-cycle key events with optional auto-repeat.
module button_ctrl #(
  parameter int N_BTN       = 5,
  parameter int DB_CYCLES   = 1000000,
  parameter int REPEAT_DLY  = 50000000,
  parameter int REPEAT_RATE = 10000000,
  parameter int CNT_W       = 27,
  localparam int CODE_W     = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic              clk,
  input  logic              rst_ext,
  input  logic [N_BTN-1:0]  btn_raw,
  input  logic              repeat_en,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_repeat,
  output logic              busy
);

  // state       | meaning
  // IDLE        | no key accepted, waiting for any synced press
  // DEB_PRESS   | candidate key must stay high for DB_CYCLES
  // HELD        | key accepted; auto-repeat timing when enabled
  // DEB_RELEASE | candidate key must stay low for DB_CYCLES
  // WAIT_ALL    | other keys still down; wait until every key is up
  typedef enum logic [2:0] {
    S_IDLE,
    S_DEB_PRESS,
    S_HELD,
    S_DEB_RELEASE,
    S_WAIT_ALL
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  state_t              state_q, state_d;
  logic [N_BTN-1:0]    sync1_q, sync2_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0]   cand_q, cand_d, low_idx;
  logic                rep_first_q, rep_first_d;
  logic                key_valid_q, key_valid_d;
  logic [CODE_W-1:0]   key_code_q, key_code_d;
  logic                key_repeat_q, key_repeat_d;
  logic                cand_hit, any_sync;

  always_ff @(posedge clk) begin
    if (rst_ext) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cand_q       <= '0;
      rep_first_q  <= 1'b0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_repeat_q <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      rep_first_q  <= rep_first_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_repeat_q <= key_repeat_d;
    end
  end

  // Lowest set index wins when several keys arrive together.
  always_comb begin
    low_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (sync2_q[i]) low_idx = CODE_W'(i);
    end
  end

  assign cand_hit = sync2_q[cand_q];
  assign any_sync = |sync2_q;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_inc;
    cand_d       = cand_q;
    rep_first_d  = rep_first_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_repeat_d = key_repeat_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_sync) begin
          cand_d  = low_idx;
          state_d = S_DEB_PRESS;
          cnt_d   = '0;
        end
      end
      S_DEB_PRESS: begin
        if (!cand_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          key_valid_d  = 1'b1;
          key_code_d   = cand_q;
          key_repeat_d = 1'b0;
          rep_first_d  = 1'b1;
          state_d      = S_HELD;
          cnt_d        = '0;
        end
      end
      S_HELD: begin
        // Release wins over a repeat threshold reached in the same cycle.
        if (!cand_hit) begin
          state_d = S_DEB_RELEASE;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          cnt_d = '0;
        end else if (cnt_q == (rep_first_q ? DLY_LAST : RATE_LAST)) begin
          key_valid_d  = 1'b1;
          key_code_d   = cand_q;
          key_repeat_d = 1'b1;
          rep_first_d  = 1'b0;
          cnt_d        = '0;
        end
      end
      S_DEB_RELEASE: begin
        if (cand_hit) begin
          state_d     = S_HELD;
          rep_first_d = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = any_sync ? S_WAIT_ALL : S_IDLE;
          cnt_d   = '0;
        end
      end
      S_WAIT_ALL: begin
        if (!any_sync) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;
  assign key_repeat = key_repeat_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl: directed scenarios plus random button traffic,
// all compared cycle by cycle against a behavioural reference model.
module tb_button_ctrl;
  localparam int N_BTN = 5;
  localparam int DB    = 4;
  localparam int DLY   = 10;
  localparam int RATE  = 3;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst_ext = 1'b1;
  logic [4:0] btn_raw = '0;
  logic       repeat_en = 1'b0;
  logic       key_valid;
  logic [2:0] key_code;
  logic       key_repeat;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_ctrl #(
    .N_BTN(N_BTN), .DB_CYCLES(DB), .REPEAT_DLY(DLY), .REPEAT_RATE(RATE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_ext(rst_ext), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .key_valid(key_valid), .key_code(key_code), .key_repeat(key_repeat), .busy(busy)
  );

  // Reference model: phase of the key's life plus how long it has been in that phase.
  localparam int PH_FREE = 0, PH_PRESSING = 1, PH_DOWN = 2, PH_LIFTING = 3, PH_OTHERS = 4;
  int         m_phase = PH_FREE;
  int         m_key = 0;
  int         m_age = 0;
  bit         m_first_wait = 1'b0;
  logic [4:0] m_seen1 = '0, m_seen2 = '0;
  logic       e_valid = 1'b0;
  logic [2:0] e_code = '0;
  logic       e_rep = 1'b0;
  logic       e_busy = 1'b0;

  function automatic int lowest_bit(logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic emit(input bit is_rep);
    e_valid = 1'b1;
    e_code  = 3'(m_key);
    e_rep   = is_rep;
  endtask

  task automatic model_edge();
    logic [4:0] seen;
    int wait_len;
    seen = m_seen2;
    if (rst_ext) begin
      m_phase = PH_FREE; m_key = 0; m_age = 0; m_first_wait = 1'b0;
      e_valid = 1'b0; e_code = '0; e_rep = 1'b0;
      m_seen1 = '0; m_seen2 = '0;
    end else begin
      e_valid = 1'b0;
      if (m_phase == PH_FREE) begin
        if (seen != 0) begin m_key = lowest_bit(seen); m_phase = PH_PRESSING; m_age = 0; end
      end else if (m_phase == PH_PRESSING) begin
        if (!seen[m_key]) begin m_phase = PH_FREE; m_age = 0; end
        else if (m_age + 1 == DB) begin emit(1'b0); m_phase = PH_DOWN; m_age = 0; m_first_wait = 1'b1; end
        else m_age++;
      end else if (m_phase == PH_DOWN) begin
        wait_len = m_first_wait ? DLY : RATE;
        if (!seen[m_key]) begin m_phase = PH_LIFTING; m_age = 0; end
        else if (!repeat_en) m_age = 0;
        else if (m_age + 1 == wait_len) begin emit(1'b1); m_age = 0; m_first_wait = 1'b0; end
        else m_age++;
      end else if (m_phase == PH_LIFTING) begin
        if (seen[m_key]) begin m_phase = PH_DOWN; m_age = 0; m_first_wait = 1'b1; end
        else if (m_age + 1 == DB) begin m_phase = (seen == 0) ? PH_FREE : PH_OTHERS; m_age = 0; end
        else m_age++;
      end else begin
        if (seen == 0) begin m_phase = PH_FREE; m_age = 0; end
      end
      m_seen2 = m_seen1;
      m_seen1 = btn_raw;
    end
    e_busy = (m_phase != PH_FREE);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ext = 1'b1; btn_raw = '0; repeat_en = 1'b0;
    step(); step();
    n_checks++;
    if ({key_valid, key_code, key_repeat, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v%0b c%0d r%0b b%0b, want all 0", key_valid, key_code, key_repeat, busy);
    end
    rst_ext = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++;
      if ({key_valid, key_code, key_repeat, busy} !== {e_valid, e_code, e_rep, e_busy}) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got v%0b c%0d r%0b b%0b, want v%0b c%0d r%0b b%0b",
                 c, key_valid, key_code, key_repeat, busy, e_valid, e_code, e_rep, e_busy);
      end
    end
  endtask

  task automatic test_clean_press();
    int npulse = 0, pcyc = -1;
    logic [2:0] pcode = '0;
    logic prep = 1'bx;
    btn_raw = 5'b00100; repeat_en = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      if (c == 31) btn_raw = '0;
      step();
      n_checks++;
      if ({key_valid, key_code, key_repeat, busy} !== {e_valid, e_code, e_rep, e_busy}) begin
        n_fail++;
        $display("FAIL clean_press cyc %0d: got v%0b c%0d r%0b b%0b, want v%0b c%0d r%0b b%0b",
                 c, key_valid, key_code, key_repeat, busy, e_valid, e_code, e_rep, e_busy);
      end
      if (key_valid === 1'b1) begin npulse++; pcyc = c; pcode = key_code; prep = key_repeat; end
      if (c == 2 || c == 3) begin
        n_checks++;
        if (busy !== (c == 3)) begin
          n_fail++;
          $display("FAIL clean_busy_rise cyc %0d: got %0b want %0b", c, busy, (c == 3));
        end
      end
    end
    n_checks++;
    if (npulse != 1 || pcyc != 7 || pcode !== 3'd2 || prep !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_pulse: got n=%0d cyc=%0d code=%0d rep=%0b, want n=1 cyc=7 code=2 rep=0",
               npulse, pcyc, pcode, prep);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clean_idle_after: busy=%0b want 0", busy); end
  endtask

  task automatic test_bounce_reject();
    logic [15:0] pat;
    int npulse = 0;
    pat = 16'b0000_0000_0011_0111;
    repeat_en = 1'b0;
    for (int c = 0; c < 16; c++) begin
      btn_raw = {4'b0, pat[c]};
      step();
      n_checks++;
      if ({key_valid, key_code, key_repeat, busy} !== {e_valid, e_code, e_rep, e_busy}) begin
        n_fail++;
        $display("FAIL bounce cyc %0d: got v%0b c%0d r%0b b%0b, want v%0b c%0d r%0b b%0b",
                 c, key_valid, key_code, key_repeat, busy, e_valid, e_code, e_rep, e_busy);
      end
      if (key_valid === 1'b1) npulse++;
    end
    n_checks++;
    if (npulse != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_result: got pulses=%0d busy=%0b, want pulses=0 busy=0", npulse, busy);
    end
  endtask

  task automatic test_auto_repeat();
    int pc[$];
    logic pr[$];
    logic [2:0] pk[$];
    repeat_en = 1'b1; btn_raw = 5'b00010;
    for (int c = 1; c <= 60; c++) begin
      if (c == 43) btn_raw = '0;
      step();
      n_checks++;
      if ({key_valid, key_code, key_repeat, busy} !== {e_valid, e_code, e_rep, e_busy}) begin
        n_fail++;
        $display("FAIL repeat cyc %0d: got v%0b c%0d r%0b b%0b, want v%0b c%0d r%0b b%0b",
                 c, key_valid, key_code, key_repeat, busy, e_valid, e_code, e_rep, e_busy);
      end
      if (key_valid === 1'b1) begin pc.push_back(c); pr.push_back(key_repeat); pk.push_back(key_code); end
    end
    n_checks++;
    if (pc.size() != 11) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d want 11", pc.size());
    end
    for (int i = 0; i < pc.size() && i < 11; i++) begin
      n_checks++;
      if (pc[i] != ((i == 0) ? 7 : 17 + 3 * (i - 1)) || pr[i] !== (i != 0) || pk[i] !== 3'd1) begin
        n_fail++;
        $display("FAIL repeat_pulse %0d: got cyc=%0d rep=%0b code=%0d, want cyc=%0d rep=%0b code=1",
                 i, pc[i], pr[i], pk[i], (i == 0) ? 7 : 17 + 3 * (i - 1), (i != 0));
      end
    end
    repeat_en = 1'b0;
  endtask

  task automatic test_rollover();
    logic [2:0] codes[$];
    bit busy_wait = 1'b0, busy_free = 1'b1;
    repeat_en = 1'b0;
    for (int c = 1; c <= 69; c++) begin
      if (c <= 15) btn_raw = 5'b10010;
      else if (c <= 35) btn_raw = 5'b10000;
      else if (c <= 45) btn_raw = 5'b00000;
      else if (c <= 57) btn_raw = 5'b10000;
      else btn_raw = 5'b00000;
      step();
      n_checks++;
      if ({key_valid, key_code, key_repeat, busy} !== {e_valid, e_code, e_rep, e_busy}) begin
        n_fail++;
        $display("FAIL rollover cyc %0d: got v%0b c%0d r%0b b%0b, want v%0b c%0d r%0b b%0b",
                 c, key_valid, key_code, key_repeat, busy, e_valid, e_code, e_rep, e_busy);
      end
      if (key_valid === 1'b1) codes.push_back(key_code);
      if (c == 35) busy_wait = busy;
      if (c == 45) busy_free = busy;
    end
    n_checks++;
    if (codes.size() != 2 || codes[0] !== 3'd1 || codes[1] !== 3'd4) begin
      n_fail++;
      $display("FAIL rollover_codes: got n=%0d first=%0d last=%0d, want n=2 codes 1,4",
               codes.size(), (codes.size() > 0) ? codes[0] : 3'd7, (codes.size() > 0) ? codes[$] : 3'd7);
    end
    n_checks++;
    if (busy_wait !== 1'b1 || busy_free !== 1'b0) begin
      n_fail++;
      $display("FAIL rollover_wait: got busy_held=%0b busy_after=%0b, want 1 and 0", busy_wait, busy_free);
    end
  endtask

  task automatic test_release_bounce();
    int pc[$];
    logic pr[$];
    repeat_en = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      btn_raw = (c <= 32 && c != 18 && c != 19) ? 5'b01000 : 5'b00000;
      step();
      n_checks++;
      if ({key_valid, key_code, key_repeat, busy} !== {e_valid, e_code, e_rep, e_busy}) begin
        n_fail++;
        $display("FAIL rel_bounce cyc %0d: got v%0b c%0d r%0b b%0b, want v%0b c%0d r%0b b%0b",
                 c, key_valid, key_code, key_repeat, busy, e_valid, e_code, e_rep, e_busy);
      end
      if (key_valid === 1'b1) begin pc.push_back(c); pr.push_back(key_repeat); end
    end
    n_checks++;
    if (pc.size() != 3 || pc[0] != 7 || pc[1] != 17 || pc[2] != 32 ||
        pr[0] !== 1'b0 || pr[1] !== 1'b1 || pr[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_bounce_pulses: got n=%0d last_cyc=%0d, want cycles 7,17,32 reps 0,1,1",
               pc.size(), (pc.size() > 0) ? pc[$] : -1);
    end
    repeat_en = 1'b0;
  endtask

  task automatic test_reset_mid_debounce();
    int pcyc = -1;
    repeat_en = 1'b0; btn_raw = 5'b00100;
    for (int c = 1; c <= 26; c++) begin
      rst_ext = (c == 6);
      if (c == 21) btn_raw = '0;
      step();
      n_checks++;
      if ({key_valid, key_code, key_repeat, busy} !== {e_valid, e_code, e_rep, e_busy}) begin
        n_fail++;
        $display("FAIL rst_mid cyc %0d: got v%0b c%0d r%0b b%0b, want v%0b c%0d r%0b b%0b",
                 c, key_valid, key_code, key_repeat, busy, e_valid, e_code, e_rep, e_busy);
      end
      if (c == 6) begin
        n_checks++;
        if ({key_valid, key_code, key_repeat, busy} !== 6'b0) begin
          n_fail++;
          $display("FAIL rst_mid_clear: got v%0b c%0d r%0b b%0b, want all 0", key_valid, key_code, key_repeat, busy);
        end
      end
      if (key_valid === 1'b1 && pcyc < 0) pcyc = c;
    end
    rst_ext = 1'b0;
    n_checks++;
    if (pcyc != 13) begin
      n_fail++;
      $display("FAIL rst_mid_latency: got first pulse cyc %0d want 13", pcyc);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    int events = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0, 1: btn_raw = '0;
          2, 3: btn_raw = 5'(1 << $urandom_range(0, 4));
          default: btn_raw = 5'($urandom);
        endcase
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
        if ($urandom_range(0, 4) == 0) repeat_en = ~repeat_en;
      end
      hold--;
      rst_ext = ($urandom_range(0, 299) == 0);
      step();
      n_checks++;
      if ({key_valid, key_code, key_repeat, busy} !== {e_valid, e_code, e_rep, e_busy}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got v%0b c%0d r%0b b%0b, want v%0b c%0d r%0b b%0b",
                 c, key_valid, key_code, key_repeat, busy, e_valid, e_code, e_rep, e_busy);
      end
      if (e_valid) events++;
    end
    rst_ext = 1'b0; btn_raw = '0; repeat_en = 1'b0;
    for (int c = 0; c < 16; c++) step();
    n_checks++;
    if (events == 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL random_summary: got events=%0d busy=%0b, want events>0 busy=0", events, busy);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_auto_repeat();
    test_rollover();
    test_release_bounce();
    test_reset_mid_debounce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
